pps_scheduler: RTL

Programmable timebase and event scheduler for the PS-PL interface. It divides `axi_aclk` into a programmable one-cycle `pps` tick and derives NCHAN periodic channel events from that tick. Pending events are queued and presented one at a time to the processing system over a valid/ready interrupt handshake with round-robin fairness. It replaces the fixed free-running PPS divider at top level and is configured from software-controlled registers.

---
 rtl/pps_scheduler_pkg.sv | 14 +
 rtl/pps_scheduler_if.sv | 13 +
 rtl/pps_scheduler_rr_arbiter.sv | 26 ++
 rtl/pps_scheduler.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pps_scheduler_pkg.sv
// Shared constants and types for the PPS timebase / event scheduler.
// Optional build macro used by this block: PPS_SCHED_TIMESTAMP_EN.
package pps_sched_pkg;

    localparam int unsigned DEFAULT_DIV = 1000000;
    localparam int unsigned MAX_NCHAN   = 8;
    localparam int unsigned CHAN_W      = 3;

    typedef enum logic [0:0] {
        IDLE,
        PRESENT
    } arb_state_t;

endpackage

// File: rtl/pps_scheduler_if.sv
// Interrupt presentation handshake between the scheduler and the processing system.
interface pps_scheduler_if;
    import pps_sched_pkg::*;

    logic              irq_valid;
    logic [CHAN_W-1:0] irq_chan;
    logic [31:0]       irq_ts;
    logic              irq_ready;

    modport master (output irq_valid, output irq_chan, output irq_ts, input irq_ready);
    modport slave  (input irq_valid, input irq_chan, input irq_ts, output irq_ready);

endinterface

// File: rtl/pps_scheduler_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or above ptr,
// wrapping to the lowest requesting index overall.
module rr_arbiter
#(
    parameter int NCHAN = 4
)(
    input  logic [NCHAN-1:0]                  req,
    input  logic [pps_sched_pkg::CHAN_W-1:0]  ptr,
    output logic [pps_sched_pkg::CHAN_W-1:0]  grant_idx,
    output logic                              any_req
);
    import pps_sched_pkg::*;

    always_comb begin
        grant_idx = '0;
        any_req   = |req;
        // Wrapped candidate first; a hit at or above ptr then overrides it.
        for (int j = NCHAN - 1; j >= 0; j--) begin
            if (req[j]) grant_idx = CHAN_W'(j);
        end
        for (int j = NCHAN - 1; j >= 0; j--) begin
            if (req[j] && (CHAN_W'(j) >= ptr)) grant_idx = CHAN_W'(j);
        end
    end

endmodule

// File: rtl/pps_scheduler.sv
// Programmable PPS divider, periodic channel events and round-robin IRQ presentation.
// Build macro PPS_SCHED_TIMESTAMP_EN adds the seconds counter and per-channel stamps.
//
// state   | meaning
// IDLE    | no event presented; grant next pending channel if any
// PRESENT | irq_valid high, channel/stamp held until irq_ready
module pps_scheduler
#(
    parameter int          NCHAN       = 4,
    parameter int          CNT_W       = 32,
    parameter int          PER_W       = 16,
    parameter int unsigned DEFAULT_DIV = pps_sched_pkg::DEFAULT_DIV
)(
    input  logic                   axi_aclk,
    input  logic                   axi_reset,
    input  logic                   enable,
    input  logic [CNT_W-1:0]       cfg_div,
    input  logic                   cfg_load,
    input  logic [NCHAN-1:0]       chan_en,
    input  logic [NCHAN*PER_W-1:0] chan_period,
    output logic                   pps,
    pps_scheduler_if.master        irq,
    output logic [NCHAN-1:0]       ovf,
    input  logic                   ovf_clr
);
    import pps_sched_pkg::*;

    logic [CNT_W-1:0]  shadow;
    logic [CNT_W-1:0]  shadow_nxt;
    logic [CNT_W-1:0]  reload_val;
    logic [CNT_W-1:0]  cnt;
    logic              tick;
    logic [NCHAN-1:0]  fire;
    logic [NCHAN-1:0]  pending;
    logic [NCHAN-1:0]  hs_clr;
    logic              hs;
    logic [CHAN_W-1:0] grant_idx;
    logic              any_req;
    logic [CHAN_W-1:0] rr_ptr;
    logic [CHAN_W-1:0] rr_nxt;
    logic [31:0]       ts_sel;
    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              valid_nxt;
    logic [CHAN_W-1:0] chan_nxt;
    logic [31:0]       ts_nxt;

    // A load in the reload cycle itself already takes effect; zero divisor means one.
    assign shadow_nxt = cfg_load ? cfg_div : shadow;
    assign reload_val = (shadow_nxt == '0) ? '0 : shadow_nxt - 1'b1;
    assign tick       = enable && (cnt == '0);

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            shadow <= CNT_W'(DEFAULT_DIV);
            cnt    <= CNT_W'(DEFAULT_DIV - 1);
            pps    <= 1'b0;
        end else begin
            shadow <= shadow_nxt;
            pps    <= tick;
            if (!enable || tick) cnt <= reload_val;
            else                 cnt <= cnt - 1'b1;
        end
    end

    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        logic [PER_W-1:0] per;
        logic [PER_W-1:0] ccnt;

        assign per     = chan_period[i*PER_W +: PER_W];
        assign fire[i] = tick && chan_en[i] && (ccnt == '0);

        always_ff @(posedge axi_aclk) begin
            if (axi_reset || !chan_en[i]) ccnt <= '0;
            else if (fire[i])             ccnt <= (per == '0) ? '0 : per - 1'b1;
            else if (tick)                ccnt <= ccnt - 1'b1;
        end
    end

    always_comb begin
        hs_clr = '0;
        for (int i = 0; i < NCHAN; i++) begin
            hs_clr[i] = hs && (irq.irq_chan == CHAN_W'(i));
        end
    end

    // A fire on the handshake cycle re-arms the bit instead of flagging overflow.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            pending <= '0;
            ovf     <= '0;
        end else begin
            pending <= (pending & ~hs_clr) | fire;
            ovf     <= (ovf & ~{NCHAN{ovf_clr}}) | (fire & pending & ~hs_clr);
        end
    end

`ifdef PPS_SCHED_TIMESTAMP_EN
    logic [31:0] sec_cnt;
    logic [31:0] ts [NCHAN];

    // The stamp counts the tick that caused the fire.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            sec_cnt <= '0;
            for (int i = 0; i < NCHAN; i++) ts[i] <= '0;
        end else begin
            if (tick) sec_cnt <= sec_cnt + 1'b1;
            for (int i = 0; i < NCHAN; i++) begin
                if (fire[i]) ts[i] <= sec_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        ts_sel = '0;
        for (int i = 0; i < NCHAN; i++) begin
            if (grant_idx == CHAN_W'(i)) ts_sel = ts[i];
        end
    end
`else
    assign ts_sel = '0;
`endif

    rr_arbiter #(.NCHAN(NCHAN)) u_rr_arbiter (
        .req       (pending),
        .ptr       (rr_ptr),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    always_comb begin
        state_nxt = state;
        valid_nxt = irq.irq_valid;
        chan_nxt  = irq.irq_chan;
        ts_nxt    = irq.irq_ts;
        rr_nxt    = rr_ptr;
        hs        = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = PRESENT;
                    valid_nxt = 1'b1;
                    chan_nxt  = grant_idx;
                    ts_nxt    = ts_sel;
                end
            end
            PRESENT: begin
                if (irq.irq_ready) begin
                    hs        = 1'b1;
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                    rr_nxt    = (irq.irq_chan == CHAN_W'(NCHAN - 1)) ? '0 : irq.irq_chan + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state         <= IDLE;
            irq.irq_valid <= 1'b0;
            irq.irq_chan  <= '0;
            irq.irq_ts    <= '0;
            rr_ptr        <= '0;
        end else begin
            state         <= state_nxt;
            irq.irq_valid <= valid_nxt;
            irq.irq_chan  <= chan_nxt;
            irq.irq_ts    <= ts_nxt;
            rr_ptr        <= rr_nxt;
        end
    end

endmodule
